bq_serial_add: RTL and testbench
================================

# bq_serial_add

Digit-serial decimal word adder for the character/numeric datapath. It accepts two DIGITS-long operands in bi-quinary digit code and adds them least-significant digit first, one digit per clock, using a registered carry. It returns the bi-quinary sum, a decimal carry-out and a code-error flag. It sits downstream of operand fetch and upstream of the result register / CHAR conversion logic, and it is the sequencing stage around the single-digit bi-quinary adder.

## Interface
- DIGITS, 10, number of decimal digits per operand (≥1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- start  in  1  request; sampled only in IDLE
- a  in  6*DIGITS  operand A; digit i occupies bits [6i+5:6i]; digit 0 = LSD
- b  in  6*DIGITS  operand B, same layout
- cin  in  1  decimal carry into digit 0
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; sum/cout/err valid from this cycle on
- sum  out  6*DIGITS  bi-quinary result, same layout
- cout  out  1  decimal carry out of the MSD
- err  out  1  some operand digit was not a legal code

## Operation
- Digit code: bits[4:0] are one-hot on d mod 5; bit5 = (d ≥ 5). Zero = 6'b000001, nine = 6'b110000.
- Legal iff exactly one of bits[4:0] is set. Any other value sets err for the operation; the sum for that digit is don't-care, but sequencing continues unchanged.
- FSM IDLE → RUN → DONE → IDLE.
  - IDLE: start=1 latches a, b into shift registers, latches cin into the carry flop, clears the digit counter and the error accumulator, then moves to RUN. start=0 keeps the FSM in IDLE.
  - RUN: each cycle, the low digits of A and B plus carry go through the digit adder. The result is shifted into the top of the result shift register, the carry flop is updated, and the operands shift right one digit. After DIGITS RUN cycles the FSM moves to DONE.
  - DONE: sum, cout and err are loaded from internal state, done=1, and the FSM returns to IDLE.
- Digit add: a+b+c with c∈{0,1}. Output digit = (a+b+c) mod 10; carry = (a+b+c) ≥ 10. Max 9+9+1 = 19 → digit 9, carry 1.
- sum, cout and err hold their values until the next DONE. They never change mid-operation.
- start while busy or in DONE is ignored. It is not queued.
- Reset values: busy 0, done 0, sum all digits 6'b000001, cout 0, err 0, FSM IDLE, carry 0, counter 0.
- rst_n low in any state aborts the operation on that edge. No done is produced, and outputs return to reset values.

## Timing
- Start accepted at edge 0. busy=1 from edge 0 through edge DIGITS. done=1 for the single cycle after edge DIGITS+1.
- Latency is start-to-done = DIGITS+1 cycles. Throughput is one operation per DIGITS+2 cycles; the earliest next start is the cycle after done.
- busy and done are never high together.
- The digit adder is purely combinational between the shift-register LSBs and the carry flop. There is one digit of logic depth per cycle, with no ripple across digits.

## Structure
- Package bq_pkg:
  - DIGIT_W = 6
  - BQ_ZERO = 6'b000001
  - state enum {IDLE, RUN, DONE}
  - function bq_legal(digit)
- Sub-module bq_digit_add is combinational. Inputs: a[5:0], b[5:0], c. Outputs: s[5:0], cout. It honours the carry-in fully.
- The top level holds the FSM, a counter of width clog2(DIGITS+1), the operand and result shift registers, the carry flop and the error flop.

## Test plan
- DIGITS=10:
  - 0000000123 + 0000000879, cin=0 → sum 0000001002, cout 0, err 0. done exactly 11 cycles after the start edge, and busy high for 10 cycles.
  - 9999999999 + 0000000001 → sum 0000000000, cout 1.
  - 0 + 0 with cin=1 → sum 0000000001, cout 0.
  - 9999999999 + 9999999999 with cin=1 → sum 9999999999, cout 1.
- Invalid digit: a digit 3 of A = 6'b000011 → err 1 at done. done timing is unchanged. A following legal operation clears err to 0.
- start pulsed again on RUN cycles 3 and 9 and on the done cycle → ignored. Exactly one done, and the sum is from the first operands.
- rst_n low for one cycle at RUN cycle 4 → busy 0 next cycle, no done pulse, sum = all BQ_ZERO, cout 0. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/bq_pkg.sv
// Shared types and constants for the digit-serial bi-quinary adder.
package bq_pkg;

    localparam int DIGIT_W = 6;
    localparam logic [DIGIT_W-1:0] BQ_ZERO = 6'b000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A digit is legal when exactly one of the quinary bits is set.
    function automatic logic bq_legal(input logic [DIGIT_W-1:0] digit);
        int n;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (digit[i]) n++;
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/bq_digit_add.sv
// Single bi-quinary digit adder: s = (a + b + c) mod 10, cout = (a + b + c) >= 10.
module bq_digit_add
    import bq_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               c,
    output logic [DIGIT_W-1:0] s,
    output logic               cout
);

    // Illegal codes decode to some value; the caller flags them separately.
    function automatic logic [3:0] bq_value(input logic [DIGIT_W-1:0] d);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 5; i++) begin
            if (d[i]) idx = 4'(i);
        end
        return (d[5] ? 4'd5 : 4'd0) + idx;
    endfunction

    logic [4:0] total;
    logic [3:0] digit;
    logic [3:0] rem;
    logic [4:0] onehot;

    always_comb begin
        total  = {1'b0, bq_value(a)} + {1'b0, bq_value(b)} + {4'd0, c};
        cout   = (total >= 5'd10);
        digit  = cout ? 4'(total - 5'd10) : total[3:0];
        rem    = (digit >= 4'd5) ? (digit - 4'd5) : digit;
        onehot = 5'b00001 << rem;
        s      = {(digit >= 4'd5), onehot};
    end

endmodule

// File: rtl/bq_serial_add.sv
// Digit-serial decimal adder: one bi-quinary digit per clock, LSD first, registered carry.
module bq_serial_add
    import bq_pkg::*;
#(
    parameter int DIGITS = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    input  logic                      cin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] sum,
    output logic                      cout,
    output logic                      err,
    output state_t                    dbg_state
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int CNT_W = (DIGITS < 2) ? 1 : $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic             carry_q, carry_d, err_acc_q, err_acc_d;
    logic             cout_q, cout_d, err_q, err_d, done_q, done_d;

    logic [DIGIT_W-1:0] dig_s;
    logic               dig_c;
    logic [W+DIGIT_W-1:0] res_shift;
    logic               accept;

    bq_digit_add u_digit (
        .a    (a_q[DIGIT_W-1:0]),
        .b    (b_q[DIGIT_W-1:0]),
        .c    (carry_q),
        .s    (dig_s),
        .cout (dig_c)
    );

    // The done cycle still belongs to the finishing operation, so start is ignored there.
    assign accept = (state_q == IDLE) && start && !done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        carry_d   = carry_q;
        err_acc_d = err_acc_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        err_d     = err_q;
        done_d    = 1'b0;
        res_shift = {dig_s, res_q};
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d       = a;
                    b_d       = b;
                    carry_d   = cin;
                    cnt_d     = '0;
                    err_acc_d = 1'b0;
                end
            end
            RUN: begin
                res_d     = res_shift[W+DIGIT_W-1:DIGIT_W];
                carry_d   = dig_c;
                a_d       = a_q >> DIGIT_W;
                b_d       = b_q >> DIGIT_W;
                cnt_d     = cnt_q + CNT_W'(1);
                err_acc_d = err_acc_q | !bq_legal(a_q[DIGIT_W-1:0])
                                      | !bq_legal(b_q[DIGIT_W-1:0]);
            end
            DONE: begin
                sum_d  = res_q;
                cout_d = carry_q;
                err_d  = err_acc_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= {DIGITS{BQ_ZERO}};
            carry_q   <= 1'b0;
            err_acc_q <= 1'b0;
            sum_q     <= {DIGITS{BQ_ZERO}};
            cout_q    <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            err_acc_q <= err_acc_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bq_serial_add.sv
// Randomized bench for bq_serial_add against a decimal-integer reference model.
module tb_bq_serial_add;
    import bq_pkg::*;

    localparam int D = 10;
    localparam int W = 6 * D;
    localparam longint P10 = 64'd10000000000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;
    state_t       dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] prev_sum;
    bit           have_prev = 1'b0;

    bq_serial_add #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] enc(input longint v);
        logic [W-1:0] r;
        logic [4:0]   oh;
        longint       t;
        int           d;
        t = v;
        r = '0;
        for (int i = 0; i < D; i++) begin
            d  = int'(t % 10);
            t  = t / 10;
            oh = 5'b00001 << (d % 5);
            r[i*6 +: 6] = {(d >= 5), oh};
        end
        return r;
    endfunction

    function automatic longint rand_num();
        longint v;
        v = 0;
        for (int i = 0; i < D; i++) begin
            v = v * 10 + (($urandom_range(0, 3) == 0) ? 9 : longint'($urandom_range(0, 9)));
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input longint va, input longint vb, input logic ci,
                          input int bad_digit, input bit pulse_extra);
        longint       tot;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        int           busy_cnt, done_at, seen;
        bit           both;
        tot      = va + vb + longint'(ci);
        exp_cout = (tot >= P10);
        exp_q.push_back(enc(tot % P10));
        a = enc(va);
        if (bad_digit >= 0) a[bad_digit*6 +: 6] = 6'b000011;
        b = enc(vb);
        cin = ci;
        start = 1'b1;
        step();
        start = 1'b0;
        busy_cnt = 0;
        done_at  = -1;
        both     = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            start = pulse_extra && (cyc == 3 || cyc == 9);
            if (cyc == 5 && have_prev) check("sum_hold", 64'(sum), 64'(prev_sum));
            if (busy) busy_cnt++;
            if (busy && done) both = 1'b1;
            if (done) begin
                done_at = cyc;
                break;
            end
            step();
        end
        start = 1'b0;
        check("done_latency", 64'(done_at), 64'd11);
        check("busy_cycles", 64'(busy_cnt), 64'd10);
        check("busy_done_excl", 64'(both), 64'd0);
        exp_sum = exp_q.pop_front();
        if (bad_digit < 0) begin
            check("sum", 64'(sum), 64'(exp_sum));
            check("cout", 64'(cout), 64'(exp_cout));
        end
        check("err", 64'(err), (bad_digit >= 0) ? 64'd1 : 64'd0);
        if (pulse_extra) begin
            start = 1'b1;
            step();
            start = 1'b0;
            seen = 0;
            for (int i = 0; i < 14; i++) begin
                if (busy || done) seen++;
                step();
            end
            check("start_ignored", 64'(seen), 64'd0);
            check("sum_after_ignore", 64'(sum), 64'(exp_sum));
        end else begin
            step();
        end
        have_prev = (bad_digit < 0);
        prev_sum  = exp_sum;
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'({D{BQ_ZERO}}));
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        have_prev = 1'b1;
        prev_sum  = {D{BQ_ZERO}};

        run_op(64'd123, 64'd879, 1'b0, -1, 1'b0);
        run_op(64'd9999999999, 64'd1, 1'b0, -1, 1'b0);
        run_op(64'd0, 64'd0, 1'b1, -1, 1'b0);
        run_op(64'd9999999999, 64'd9999999999, 1'b1, -1, 1'b0);
        run_op(64'd4567891234, 64'd1111111111, 1'b0, 3, 1'b0);
        run_op(64'd4567891234, 64'd1111111111, 1'b0, -1, 1'b0);
        run_op(64'd5555555555, 64'd4444444445, 1'b0, -1, 1'b1);

        for (int n = 0; n < 8; n++) begin
            run_op(rand_num(), rand_num(), 1'($urandom_range(0, 1)), -1, 1'b0);
        end

        a = enc(64'd8888888888);
        b = enc(64'd7777777777);
        cin = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum", 64'(sum), 64'({D{BQ_ZERO}}));
        check("abort_cout", 64'(cout), 64'd0);
        check("abort_state", 64'(dbg_state), 64'(IDLE));
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (busy || done) seen++;
            step();
        end
        check("abort_quiet", 64'(seen), 64'd0);
        have_prev = 1'b1;
        prev_sum  = {D{BQ_ZERO}};
        run_op(64'd8888888888, 64'd7777777777, 1'b1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
